// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: requester-side and i2c_controller-side signals of the bus arbiter.
interface i2c_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_in;
    logic [7*NUM_REQ-1:0] req_addr_in;
    logic [NUM_REQ-1:0]   req_rw_in;
    logic [8*NUM_REQ-1:0] req_cmd_in;
    logic [8*NUM_REQ-1:0] req_data_in;
    logic [NUM_REQ-1:0]   grant_out;
    logic [NUM_REQ-1:0]   done_out;
    logic                 err_out;
    logic [7:0]           rdata_out;
    logic                 busy_out;
    logic                 i2c_start_out;
    logic [6:0]           i2c_addr_out;
    logic                 i2c_rw_out;
    logic [7:0]           i2c_cmd_out;
    logic [7:0]           i2c_data_out;
    logic [7:0]           i2c_data_in;
    logic                 i2c_valid_in;

    modport slave (
        input  req_in, req_addr_in, req_rw_in, req_cmd_in, req_data_in, i2c_data_in, i2c_valid_in,
        output grant_out, done_out, err_out, rdata_out, busy_out,
               i2c_start_out, i2c_addr_out, i2c_rw_out, i2c_cmd_out, i2c_data_out
    );

    modport master (
        output req_in, req_addr_in, req_rw_in, req_cmd_in, req_data_in, i2c_data_in, i2c_valid_in,
        input  grant_out, done_out, err_out, rdata_out, busy_out,
               i2c_start_out, i2c_addr_out, i2c_rw_out, i2c_cmd_out, i2c_data_out
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one i2c_controller among NUM_REQ requesters,
// one start per grant, with a watchdog that aborts a transaction lacking data_valid.
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input logic              clk_in,
    input logic              rst_in,
    i2c_bus_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t             state_q;
    logic [IW-1:0]      ptr_q, win, idx;
    logic               found;
    logic [TW-1:0]      timer_q;
    logic [NUM_REQ-1:0] grant_q, done_q;
    logic               err_q, busy_q, start_q, rw_q;
    logic [6:0]         addr_q;
    logic [7:0]         cmd_q, data_q, rdata_q;
    logic [6:0]         addr_a [NUM_REQ];
    logic [7:0]         cmd_a  [NUM_REQ];
    logic [7:0]         data_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign addr_a[g] = bus.req_addr_in[7*g +: 7];
        assign cmd_a[g]  = bus.req_cmd_in[8*g +: 8];
        assign data_a[g] = bus.req_data_in[8*g +: 8];
    end

    // Scan from the far end back toward ptr so the closest requester wins last.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.req_in[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            timer_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    grant_q <= NUM_REQ'(1) << win;
                    addr_q  <= addr_a[win];
                    rw_q    <= bus.req_rw_in[win];
                    cmd_q   <= cmd_a[win];
                    data_q  <= data_a[win];
                    ptr_q   <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    start_q <= 1'b1;
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    start_q <= 1'b0;
                    timer_q <= timer_q + 1'b1;
                    if (bus.i2c_valid_in) begin
                        rdata_q <= bus.i2c_data_in;
                        done_q  <= grant_q;
                        state_q <= RELEASE;
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        done_q  <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    grant_q <= '0;
                    done_q  <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant_out     = grant_q;
    assign bus.done_out      = done_q;
    assign bus.err_out       = err_q;
    assign bus.rdata_out     = rdata_q;
    assign bus.busy_out      = busy_q;
    assign bus.i2c_start_out = start_q;
    assign bus.i2c_addr_out  = addr_q;
    assign bus.i2c_rw_out    = rw_q;
    assign bus.i2c_cmd_out   = cmd_q;
    assign bus.i2c_data_out  = data_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed stimulus with a scoreboard of expected grants, starts and
// done pulses; an i2c_controller BFM answers each start after a per-requester delay.
module tb_i2c_bus_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    typedef struct {
        logic [N-1:0] done;
        logic         err;
        logic [7:0]   rdata;
        int           lat;
    } done_t;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] cmd;
        logic [7:0] data;
    } start_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_bus_arbiter_if #(.NUM_REQ(N)) bus ();
    i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    logic [N-1:0] req = '0;
    logic [6:0]   f_addr [N];
    logic         f_rw   [N];
    logic [7:0]   f_cmd  [N];
    logic [7:0]   f_data [N];
    int           bfm_delay [N];
    logic [7:0]   bfm_data  [N];
    logic         bfm_valid = 1'b0;
    logic [7:0]   bfm_rdata = '0;
    logic         tb_valid  = 1'b0;
    logic [7:0]   tb_data   = '0;

    assign bus.req_in       = req;
    assign bus.i2c_valid_in = bfm_valid | tb_valid;
    assign bus.i2c_data_in  = bfm_valid ? bfm_rdata : tb_data;
    for (genvar g = 0; g < N; g++) begin : g_req
        assign bus.req_addr_in[7*g +: 7] = f_addr[g];
        assign bus.req_rw_in[g]          = f_rw[g];
        assign bus.req_cmd_in[8*g +: 8]  = f_cmd[g];
        assign bus.req_data_in[8*g +: 8] = f_data[g];
    end

    done_t        exp_done  [$];
    start_t       exp_start [$];
    logic [N-1:0] exp_grant [$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int grant_cyc = 0;
    int start_cyc = 0;
    logic [N-1:0] prev_g = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // BFM: answers a start after bfm_delay[owner] cycles; negative delay never answers.
    int   b_cnt = 0;
    logic b_armed = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            bfm_valid = 1'b0;
            if (rst) b_armed = 1'b0;
            else if (bus.i2c_start_out) begin
                for (int i = 0; i < N; i++)
                    if (bus.grant_out[i]) begin
                        b_armed   = bfm_delay[i] >= 0;
                        b_cnt     = bfm_delay[i];
                        bfm_rdata = bfm_data[i];
                    end
            end
            if (b_armed) begin
                if (b_cnt == 0) begin
                    bfm_valid = 1'b1;
                    b_armed   = 1'b0;
                end else b_cnt--;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant, start or done.
    initial begin
        start_t s;
        done_t  d;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_g == '0 && bus.grant_out != '0) begin
                chk("grant_onehot", 32'($onehot(bus.grant_out)), 32'd1);
                if (exp_grant.size() == 0) chk("grant_unexpected", 32'(bus.grant_out), 32'd0);
                else chk("grant_owner", 32'(bus.grant_out), 32'(exp_grant.pop_front()));
                grant_cyc = cyc;
            end
            prev_g = bus.grant_out;
            if (bus.i2c_start_out) begin
                chk("start_after_grant", cyc - grant_cyc, 32'd1);
                start_cyc = cyc;
                if (exp_start.size() == 0) chk("start_unexpected", 32'(bus.i2c_start_out), 32'd0);
                else begin
                    s = exp_start.pop_front();
                    chk("start_fields", {bus.i2c_addr_out, bus.i2c_rw_out, bus.i2c_cmd_out, bus.i2c_data_out},
                        {s.addr, s.rw, s.cmd, s.data});
                end
            end
            if (bus.done_out != '0) begin
                if (exp_done.size() == 0) chk("done_unexpected", 32'(bus.done_out), 32'd0);
                else begin
                    d = exp_done.pop_front();
                    chk("done_owner", 32'(bus.done_out), 32'(d.done));
                    chk("done_err", 32'(bus.err_out), 32'(d.err));
                    chk("done_rdata", 32'(bus.rdata_out), 32'(d.rdata));
                    chk("done_latency", cyc - start_cyc, d.lat);
                end
            end else if (bus.err_out) chk("err_without_done", 32'(bus.err_out), 32'd0);
        end
    end

    task automatic expect_txn(input int r, input int lat, input logic err, input logic [7:0] rd);
        start_t s;
        done_t  d;
        s.addr = f_addr[r];
        s.rw   = f_rw[r];
        s.cmd  = f_cmd[r];
        s.data = f_data[r];
        d.done = N'(1) << r;
        d.err  = err;
        d.rdata = rd;
        d.lat  = lat;
        exp_grant.push_back(N'(1) << r);
        exp_start.push_back(s);
        exp_done.push_back(d);
    endtask

    task automatic set_req(input int r, input logic [6:0] a, input logic rw, input logic [7:0] c, input logic [7:0] dt);
        f_addr[r] = a;
        f_rw[r]   = rw;
        f_cmd[r]  = c;
        f_data[r] = dt;
    endtask

    // stop_after == 0: each requester drops after its own done; otherwise all drop after that many dones.
    task automatic run(input int stop_after);
        int  cnt = 0;
        bit  fin = 0;
        for (int t = 0; t < 2000 && !fin; t++) begin
            @(negedge clk);
            if (bus.done_out != '0) begin
                cnt++;
                if (stop_after == 0) req = req & ~bus.done_out;
                else if (cnt == stop_after) req = '0;
            end
            fin = (req == '0) && !bus.busy_out;
        end
        if (!fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_budget: got busy=%0b req=%b, expected idle", bus.busy_out, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < N; i++) begin
            set_req(i, 7'h0, 1'b0, 8'h0, 8'h0);
            bfm_delay[i] = 0;
            bfm_data[i]  = 8'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {bus.grant_out, bus.done_out, bus.err_out, bus.busy_out, bus.i2c_start_out, bus.i2c_rw_out}, 32'd0);
        chk("rst_fields", {bus.i2c_addr_out, bus.i2c_cmd_out, bus.i2c_data_out, bus.rdata_out}, 32'd0);
        rst = 1'b0;

        // 1: single read from requester 1
        set_req(1, 7'h5A, 1'b1, 8'h5D, 8'h00);
        bfm_delay[1] = 20;
        bfm_data[1]  = 8'h24;
        expect_txn(1, 21, 1'b0, 8'h24);
        req = 4'b0010;
        @(negedge clk);
        chk("t1_grant_next", 32'(bus.grant_out), 32'h2);
        chk("t1_no_start_yet", 32'(bus.i2c_start_out), 32'd0);
        run(0);
        chk("t1_rdata_hold", 32'(bus.rdata_out), 32'h24);

        // 2: simultaneous requests 0 and 2 after reset
        do_reset();
        set_req(0, 7'h10, 1'b0, 8'h01, 8'h11);
        set_req(2, 7'h22, 1'b1, 8'h02, 8'h77);
        bfm_delay[0] = 3; bfm_data[0] = 8'h33;
        bfm_delay[2] = 3; bfm_data[2] = 8'h33;
        expect_txn(0, 4, 1'b0, 8'h33);
        expect_txn(2, 4, 1'b0, 8'h33);
        req = 4'b0101;
        run(0);

        // 3: requesters 0..2 held continuously, round-robin order
        for (int i = 0; i < 3; i++) begin
            bfm_delay[i] = 0;
            bfm_data[i]  = 8'h44;
        end
        for (int k = 0; k < 6; k++) expect_txn(k % 3, 1, 1'b0, 8'h44);
        req = 4'b0111;
        run(6);

        // 4: watchdog timeout on requester 3, then requester 1 served normally
        set_req(3, 7'h7F, 1'b0, 8'hFF, 8'h80);
        bfm_delay[3] = -1;
        bfm_delay[1] = 5;
        bfm_data[1]  = 8'h55;
        expect_txn(3, 64, 1'b1, 8'h44);
        expect_txn(1, 6, 1'b0, 8'h55);
        req = 4'b1010;
        run(0);

        // 5: stray valid in IDLE, then valid coincident with timeout
        tb_data  = 8'hAA;
        tb_valid = 1'b1;
        @(negedge clk);
        tb_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_rdata_unchanged", 32'(bus.rdata_out), 32'h55);
        chk("t5_idle", {bus.busy_out, bus.grant_out}, 32'd0);
        bfm_delay[0] = 63;
        bfm_data[0]  = 8'h66;
        expect_txn(0, 64, 1'b0, 8'h66);
        req = 4'b0001;
        run(0);

        // 6: reset mid-WAIT, then round-robin restarts from requester 0
        bfm_delay[2] = -1;
        exp_grant.push_back(4'b0100);
        begin
            start_t s;
            s.addr = f_addr[2]; s.rw = f_rw[2]; s.cmd = f_cmd[2]; s.data = f_data[2];
            exp_start.push_back(s);
        end
        req  = 4'b0100;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = bus.i2c_start_out;
        end
        chk("t6_start_seen", 32'(seen), 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_ctrl", {bus.grant_out, bus.done_out, bus.err_out, bus.busy_out, bus.i2c_start_out, bus.i2c_rw_out}, 32'd0);
        chk("t6_rst_fields", {bus.i2c_addr_out, bus.i2c_cmd_out, bus.i2c_data_out, bus.rdata_out}, 32'd0);
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        bfm_delay[1] = 2; bfm_data[1] = 8'h12;
        bfm_delay[3] = 1; bfm_data[3] = 8'h34;
        expect_txn(1, 3, 1'b0, 8'h12);
        expect_txn(3, 2, 1'b0, 8'h34);
        req = 4'b1010;
        run(0);

        repeat (3) @(negedge clk);
        chk("sb_grant_drained", exp_grant.size(), 32'd0);
        chk("sb_start_drained", exp_start.size(), 32'd0);
        chk("sb_done_drained", exp_done.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
